// File: rtl/wb_axis_stream_bridge.sv
// wb_axis_stream_bridge: Wishbone to AXI-Stream adapter with TX/RX FIFOs, status and control registers.
// Define WBAXIS_TIMEOUT_EN to bound stalled accesses to TIMEOUT cycles.
module wb_axis_stream_bridge #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic        axis_clk,
  input  logic        axis_rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [7:0]  wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        ss_tvalid,
  output logic [31:0] ss_tdata,
  output logic        ss_tlast,
  input  logic        ss_tready,
  input  logic        sm_tvalid,
  input  logic [31:0] sm_tdata,
  input  logic        sm_tlast,
  output logic        sm_tready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, ACK} state_t;
  state_t state;
  logic [31:0] tx_mem [DEPTH];
  logic [31:0] rx_mem [DEPTH];
  logic tx_lmem [DEPTH];
  logic rx_lmem [DEPTH];
  logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic tx_full, rx_empty, acc, dat_adr, sel_f, is_tx, is_rx, is_ctl, st_rd;
  logic stall, go, flush, tx_push, tx_pop, rx_push, rx_pop, tmo_fire, tmo_err, last_seen;
  logic [31:0] status;
  assign tx_full  = tx_cnt == CW'(DEPTH);
  assign rx_empty = rx_cnt == '0;
  assign acc      = state == IDLE && wbs_cyc_i && wbs_stb_i;
  assign dat_adr  = wbs_adr_i == 8'h00 || wbs_adr_i == 8'h04;
  assign sel_f    = wbs_sel_i == 4'hF;
  assign is_tx    = acc && wbs_we_i && sel_f && dat_adr;
  assign is_rx    = acc && !wbs_we_i && sel_f && dat_adr;
  assign is_ctl   = acc && wbs_we_i && sel_f && wbs_adr_i == 8'h08;
  assign st_rd    = acc && !wbs_we_i && sel_f && wbs_adr_i == 8'h08;
  assign stall    = (is_tx && tx_full) || (is_rx && rx_empty);
  assign go       = acc && (!stall || tmo_fire);
  assign flush    = is_ctl && wbs_dat_i[0];
  assign tx_push  = is_tx && !tx_full;
  assign rx_pop   = is_rx && !rx_empty;
  assign tx_pop   = ss_tvalid && ss_tready && !flush;
  assign rx_push  = sm_tvalid && sm_tready && !flush;
  assign ss_tvalid = tx_cnt != '0;
  assign ss_tdata  = ss_tvalid ? tx_mem[tx_rd] : '0;
  assign ss_tlast  = ss_tvalid && tx_lmem[tx_rd];
  assign sm_tready = rx_cnt != CW'(DEPTH);
  assign status = {13'd0, tmo_err, last_seen, !rx_empty && rx_lmem[rx_rd], 8'(rx_cnt), 8'(tx_cnt)};
`ifdef WBAXIS_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic tmo_err_q;
  assign tmo_fire = stall && tmo_cnt == 32'(TIMEOUT - 1);
  assign tmo_err  = tmo_err_q;
  always_ff @(posedge axis_clk or negedge axis_rst_n)
    if (!axis_rst_n) begin
      tmo_cnt   <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt   <= (stall && !tmo_fire) ? tmo_cnt + 32'd1 : '0;
      tmo_err_q <= tmo_fire || (tmo_err_q && !(is_ctl && wbs_dat_i[1]));
    end
`else
  logic unused_tmo;
  assign unused_tmo = TIMEOUT > 0;
  assign tmo_fire = 1'b0;
  assign tmo_err  = 1'b0;
`endif
  always_ff @(posedge axis_clk) begin
    if (tx_push) begin
      tx_mem[tx_wr]  <= wbs_dat_i;
      tx_lmem[tx_wr] <= wbs_adr_i[2];
    end
    if (rx_push) begin
      rx_mem[rx_wr]  <= sm_tdata;
      rx_lmem[rx_wr] <= sm_tlast;
    end
  end
  always_ff @(posedge axis_clk or negedge axis_rst_n)
    if (!axis_rst_n) begin
      tx_wr <= '0; tx_rd <= '0; tx_cnt <= '0;
      rx_wr <= '0; rx_rd <= '0; rx_cnt <= '0;
    end else if (flush) begin
      tx_wr <= '0; tx_rd <= '0; tx_cnt <= '0;
      rx_wr <= '0; rx_rd <= '0; rx_cnt <= '0;
    end else begin
      tx_wr  <= tx_wr + AW'(tx_push);
      tx_rd  <= tx_rd + AW'(tx_pop);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
      rx_wr  <= rx_wr + AW'(rx_push);
      rx_rd  <= rx_rd + AW'(rx_pop);
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
    end
  // a status read clears the sticky tlast flag unless a new tlast lands in the same cycle
  always_ff @(posedge axis_clk or negedge axis_rst_n)
    if (!axis_rst_n) begin
      state     <= IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      last_seen <= 1'b0;
    end else begin
      last_seen <= (rx_push && sm_tlast) || (last_seen && !st_rd);
      wbs_ack_o <= go;
      state     <= go ? ACK : IDLE;
      if (go)
        wbs_dat_o <= rx_pop ? rx_mem[rx_rd] : st_rd ? status : tmo_fire ? 32'hDEAD_BEEF : '0;
    end
endmodule

// File: tb/tb_wb_axis_stream_bridge.sv
// tb_wb_axis_stream_bridge: directed checks of the WB/AXIS bridge FIFOs, status and reset behaviour.
module tb_wb_axis_stream_bridge;
  logic clk = 0, rst_n = 0;
  logic cyc = 0, stb = 0, we = 0, ack;
  logic [3:0] sel = 4'hF;
  logic [7:0] adr = '0;
  logic [31:0] dat_i = '0, dat_o, ss_tdata, sm_tdata = '0, r;
  logic ss_tvalid, ss_tlast, ss_tready = 0, sm_tvalid = 0, sm_tlast = 0, sm_tready;
  int n_chk = 0, n_err = 0, n;

  wb_axis_stream_bridge #(.DEPTH(16), .TIMEOUT(8)) dut (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr),
    .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [31:0] rd, output int cycles);
    cyc = 1; stb = 1; we = w; adr = a; dat_i = d; sel = s; cycles = 0;
    do begin tick(); cycles++; end while (!ack && cycles < 100);
    if (!ack) begin
      n_chk++; n_err++;
      $display("FAIL wb_no_ack adr %h", a);
    end
    rd = dat_o;
    cyc = 0; stb = 0; we = 0; sel = 4'hF;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_ack", ack, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_ss_tvalid", ss_tvalid, 0);
    chk("rst_ss_tlast", ss_tlast, 0);
    chk("rst_sm_tready", sm_tready, 1);
    rst_n = 1;
    tick();
    // 1) two pushes, head order and tlast flags
    wb(1, 8'h00, 32'h11, 4'hF, r, n);
    chk("t1_ack_lat0", n, 1);
    chk("t1_ack_pulse", ack, 0);
    wb(1, 8'h04, 32'h22, 4'hF, r, n);
    chk("t1_ack_lat1", n, 1);
    chk("t1_valid", ss_tvalid, 1);
    chk("t1_head0", ss_tdata, 32'h11);
    chk("t1_last0", ss_tlast, 0);
    ss_tready = 1;
    tick();
    chk("t1_head1", ss_tdata, 32'h22);
    chk("t1_last1", ss_tlast, 1);
    tick();
    ss_tready = 0;
    chk("t1_empty", ss_tvalid, 0);
    wb(1, 8'h00, 32'h33, 4'h3, r, n);
    chk("t1_sel_ack", n, 1);
    chk("t1_sel_nopush", ss_tvalid, 0);
    wb(0, 8'h10, 32'h0, 4'hF, r, n);
    chk("t1_other_rd", r, 0);
    // 2) TX full backpressure
    for (int i = 0; i < 16; i++) wb(1, 8'h00, 32'h100 + i, 4'hF, r, n);
    wb(0, 8'h08, 32'h0, 4'hF, r, n);
    chk("t2_status_full", r, 32'h10);
    cyc = 1; stb = 1; we = 1; adr = 8'h00; dat_i = 32'h1FF;
    repeat (4) tick();
    chk("t2_ack_held", ack, 0);
    ss_tready = 1;
    tick();
    ss_tready = 0;
    chk("t2_ack_at_pop", ack, 0);
    chk("t2_head_after_pop", ss_tdata, 32'h101);
    tick();
    chk("t2_ack_after_pop", ack, 1);
    cyc = 0; stb = 0; we = 0;
    tick();
    wb(0, 8'h08, 32'h0, 4'hF, r, n);
    chk("t2_status_refill", r, 32'h10);
    ss_tready = 1;
    repeat (15) tick();
    chk("t2_tail", ss_tdata, 32'h1FF);
    tick();
    ss_tready = 0;
    chk("t2_drained", ss_tvalid, 0);
    // 3) RX capture, status and pops
    chk("t3_sm_tready", sm_tready, 1);
    sm_tvalid = 1; sm_tdata = 32'hA; sm_tlast = 0;
    tick();
    sm_tdata = 32'hB; sm_tlast = 1;
    tick();
    sm_tvalid = 0; sm_tlast = 0;
    wb(0, 8'h08, 32'h0, 4'hF, r, n);
    chk("t3_status", r, 32'h0002_0200);
    wb(0, 8'h00, 32'h0, 4'hF, r, n);
    chk("t3_pop0", r, 32'hA);
    wb(0, 8'h08, 32'h0, 4'hF, r, n);
    chk("t3_status_head_last", r, 32'h0001_0100);
    wb(0, 8'h04, 32'h0, 4'hF, r, n);
    chk("t3_pop1", r, 32'hB);
    wb(0, 8'h08, 32'h0, 4'hF, r, n);
    chk("t3_status_clear", r, 32'h0);
    // 4) read stalls on empty RX until a word arrives
    cyc = 1; stb = 1; we = 0; adr = 8'h00;
    repeat (5) tick();
    chk("t4_ack_held", ack, 0);
    sm_tvalid = 1; sm_tdata = 32'h55;
    tick();
    sm_tvalid = 0;
    chk("t4_no_bypass", ack, 0);
    tick();
    chk("t4_ack", ack, 1);
    chk("t4_data", dat_o, 32'h55);
    cyc = 0; stb = 0;
    tick();
    // 5) flush, then reset mid-access
    for (int i = 0; i < 3; i++) wb(1, 8'h00, 32'h200 + i, 4'hF, r, n);
    wb(0, 8'h08, 32'h0, 4'hF, r, n);
    chk("t5_status3", r, 32'h3);
    wb(1, 8'h08, 32'h1, 4'hF, r, n);
    chk("t5_flush_valid", ss_tvalid, 0);
    wb(0, 8'h08, 32'h0, 4'hF, r, n);
    chk("t5_flush_status", r, 32'h0);
    wb(1, 8'h04, 32'h77, 4'hF, r, n);
    wb(0, 8'h08, 32'h0, 4'hF, r, n);
    chk("t5_pre_rst_status", r, 32'h1);
    cyc = 1; stb = 1; we = 0; adr = 8'h00;
    repeat (2) tick();
    rst_n = 0;
    #1;
    chk("t5_rst_ack", ack, 0);
    chk("t5_rst_dat", dat_o, 0);
    chk("t5_rst_ss_tvalid", ss_tvalid, 0);
    chk("t5_rst_ss_tlast", ss_tlast, 0);
    chk("t5_rst_sm_tready", sm_tready, 1);
    cyc = 0; stb = 0;
    tick();
    rst_n = 1;
    tick();
    chk("t5_post_rst_ack", ack, 0);
    wb(0, 8'h08, 32'h0, 4'hF, r, n);
    chk("t5_post_rst_status", r, 32'h0);
`ifdef WBAXIS_TIMEOUT_EN
    // 6) timed-out read of empty RX
    wb(0, 8'h00, 32'h0, 4'hF, r, n);
    chk("t6_tmo_lat", n, 8);
    chk("t6_tmo_data", r, 32'hDEAD_BEEF);
    wb(0, 8'h08, 32'h0, 4'hF, r, n);
    chk("t6_tmo_status", r, 32'h0004_0000);
    wb(1, 8'h08, 32'h2, 4'hF, r, n);
    wb(0, 8'h08, 32'h0, 4'hF, r, n);
    chk("t6_tmo_cleared", r, 32'h0);
`else
    wb(1, 8'h08, 32'h2, 4'hF, r, n);
    wb(0, 8'h08, 32'h0, 4'hF, r, n);
    chk("t6_ctl_bit1_status", r, 32'h0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
